// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, default width and counter sizing for the div block
package div_pkg;

  localparam int DIV_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } div_state_e;

  // Iteration counter must hold the value WIDTH itself
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_if.sv
// rtl/div_if.sv - start/busy request and result bundle for the div block
interface div_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
);

  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             err;

  modport master (
    output a_i, b_i, start,
    input  busy, quotient, remainder, err
  );

  modport slave (
    input  a_i, b_i, start,
    output busy, quotient, remainder, err
  );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] d_ext;
  logic             take;

  // Shift the next dividend bit in, then subtract the divisor if it fits
  always_comb begin
    r_sh  = {r_in, q_in[WIDTH-1]};
    d_ext = (WIDTH+2)'(d_in);
    take  = (r_sh >= d_ext);
    q_out = {q_in[WIDTH-2:0], take};
    r_out = take ? (WIDTH+1)'(r_sh - d_ext) : (WIDTH+1)'(r_sh);
  end

endmodule

// File: rtl/div.sv
// rtl/div.sv - sequential unsigned restoring divider, one quotient bit per clock; option DIV_ZERO_DETECT_EN
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input logic clk,
  input logic rst,
  div_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_e       state, state_nxt;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             busy_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             zero_trap;
  logic             load;
  logic             step;
  logic             finish;
  logic             trap;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_trap = (bus.b_i == '0);
`else
  assign zero_trap = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d_in  (d_q),
    .r_out (r_nxt),
    .q_out (q_nxt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: start only honoured from IDLE; last step returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start && !zero_trap) state_nxt = CALC;
      CALC: if (cnt_q == CNT_ONE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    load   = (state == IDLE) && bus.start && !zero_trap;
    trap   = (state == IDLE) && bus.start && zero_trap;
    step   = (state == CALC);
    finish = (state == CALC) && (cnt_q == CNT_ONE);
  end

  // Work registers, result registers and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= (state_nxt == CALC);
      if (load) begin
        r_q   <= '0;
        q_q   <= bus.a_i;
        d_q   <= bus.b_i;
        cnt_q <= CNT_INIT;
      end
      if (step) begin
        r_q   <= r_nxt;
        q_q   <= q_nxt;
        cnt_q <= cnt_q - CNT_ONE;
      end
      if (finish) begin
        quot_q <= q_nxt;
        rem_q  <= r_nxt[WIDTH-1:0];
      end
      if (trap) begin
        quot_q <= '1;
        rem_q  <= bus.a_i;
      end
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic err_q;

  // Divide-by-zero flag: set on a trapped start, cleared by an accepted one
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       err_q <= 1'b0;
    else if (trap) err_q <= 1'b1;
    else if (load) err_q <= 1'b0;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy      = busy_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed self-checking bench for div (default WIDTH, either DIV_ZERO_DETECT_EN setting)
module tb_div;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_if #(.WIDTH(8)) bus ();

  div #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one division; optionally pulse a competing start (50/5) at busy cycle index inj
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int inj,
                         output int cycles, output logic hold_ok);
    logic [7:0] pq;
    logic [7:0] pr;
    @(negedge clk);
    pq = bus.quotient;
    pr = bus.remainder;
    bus.a_i   = a;
    bus.b_i   = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cycles  = 0;
    hold_ok = 1'b1;
    while (bus.busy && cycles < 40) begin
      if (bus.quotient !== pq || bus.remainder !== pr) hold_ok = 1'b0;
      if (cycles == inj) begin
        bus.a_i   = 8'd50;
        bus.b_i   = 8'd5;
        bus.start = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cycles++;
    end
  endtask

  int   cyc;
  logic hold;
  logic extra_busy;

  initial begin
    checks = 0;
    errors = 0;
    rst       = 1'b1;
    bus.a_i   = '0;
    bus.b_i   = '0;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_quot", 32'(bus.quotient), 0);
    check("rst_rem", 32'(bus.remainder), 0);
    check("rst_err", 32'(bus.err), 0);
    @(negedge clk);
    rst = 1'b0;

    run_div(8'd200, 8'd7, -1, cyc, hold);
    check("basic_quot", 32'(bus.quotient), 28);
    check("basic_rem", 32'(bus.remainder), 4);
    check("basic_cycles", 32'(cyc), 8);
    check("basic_hold", 32'(hold), 1);
    check("basic_err", 32'(bus.err), 0);

    run_div(8'd6, 8'd3, -1, cyc, hold);
    check("6_3_quot", 32'(bus.quotient), 2);
    check("6_3_rem", 32'(bus.remainder), 0);
    check("6_3_hold", 32'(hold), 1);
    check("6_3_cycles", 32'(cyc), 8);

    run_div(8'd5, 8'd9, -1, cyc, hold);
    check("5_9_quot", 32'(bus.quotient), 0);
    check("5_9_rem", 32'(bus.remainder), 5);
    check("5_9_hold", 32'(hold), 1);

    run_div(8'd255, 8'd1, -1, cyc, hold);
    check("255_1_quot", 32'(bus.quotient), 255);
    check("255_1_rem", 32'(bus.remainder), 0);
    run_div(8'd255, 8'd255, -1, cyc, hold);
    check("255_255_quot", 32'(bus.quotient), 1);
    check("255_255_rem", 32'(bus.remainder), 0);
    run_div(8'd0, 8'd17, -1, cyc, hold);
    check("0_17_quot", 32'(bus.quotient), 0);
    check("0_17_rem", 32'(bus.remainder), 0);

    run_div(8'd13, 8'd0, -1, cyc, hold);
    check("dz_quot", 32'(bus.quotient), 255);
    check("dz_rem", 32'(bus.remainder), 13);
`ifdef DIV_ZERO_DETECT_EN
    check("dz_cycles", 32'(cyc), 0);
    check("dz_err", 32'(bus.err), 1);
`else
    check("dz_cycles", 32'(cyc), 8);
    check("dz_err", 32'(bus.err), 0);
`endif
    run_div(8'd9, 8'd2, -1, cyc, hold);
    check("9_2_quot", 32'(bus.quotient), 4);
    check("9_2_rem", 32'(bus.remainder), 1);
    check("9_2_err", 32'(bus.err), 0);

    run_div(8'd100, 8'd3, 2, cyc, hold);
    check("sdb_quot", 32'(bus.quotient), 33);
    check("sdb_rem", 32'(bus.remainder), 1);
    check("sdb_cycles", 32'(cyc), 8);
    extra_busy = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.busy) extra_busy = 1'b1;
    end
    check("sdb_no_second", 32'(extra_busy), 0);
    check("sdb_quot_kept", 32'(bus.quotient), 33);

    // start held high across the completing edge: re-accepted one cycle later
    @(negedge clk);
    bus.a_i   = 8'd6;
    bus.b_i   = 8'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("b2b_cycles", 32'(cyc), 8);
    check("b2b_quot", 32'(bus.quotient), 2);
    @(posedge clk);
    #1;
    check("b2b_restart", 32'(bus.busy), 1);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("b2b_cycles2", 32'(cyc), 8);

    @(negedge clk);
    bus.a_i   = 8'd90;
    bus.b_i   = 8'd4;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_quot", 32'(bus.quotient), 0);
    check("mid_rst_rem", 32'(bus.remainder), 0);
    check("mid_rst_err", 32'(bus.err), 0);
    @(negedge clk);
    rst = 1'b0;
    run_div(8'd100, 8'd10, -1, cyc, hold);
    check("post_rst_quot", 32'(bus.quotient), 10);
    check("post_rst_rem", 32'(bus.remainder), 0);
    check("post_rst_cycles", 32'(cyc), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
